// File: rtl/dsm_decimator.sv
// Third-order CIC (sinc3) decimator for the DSM modulator code: settles over three
// decimated outputs, then emits one sample per DECIMATION inputs on a valid/ready port.
module dsm_decimator #(
    parameter int MOD_BITS   = 4,
    parameter int DECIMATION = 64,
    parameter int OUT_BITS   = MOD_BITS + 3 * $clog2(DECIMATION)
) (
    input  logic                internal_clk,
    input  logic                internal_rst,
    input  logic                enable,
    input  logic [MOD_BITS-1:0] dsm_bit,
    input  logic                dsm_valid,
    output logic [OUT_BITS-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    input  logic                clear_overrun,
    output logic [15:0]         sample_count
);
    localparam int PHASE_BITS = $clog2(DECIMATION);
    localparam int STAGES     = 3;

    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

    state_t                state_reg;
    logic [PHASE_BITS-1:0] phase_reg;
    logic [1:0]            discard_reg;
    logic [OUT_BITS-1:0]   integ_reg    [STAGES];
    logic [OUT_BITS-1:0]   comb_dly_reg [STAGES];

    logic [OUT_BITS-1:0]   integ_in [STAGES];
    logic [OUT_BITS-1:0]   comb_in  [STAGES];
    logic [OUT_BITS-1:0]   comb_out [STAGES];

    logic active, go_idle, accept, tick, emit, transfer;

    assign active   = (state_reg != IDLE);
    assign go_idle  = active && !enable;
    assign accept   = active && enable && dsm_valid;
    assign tick     = accept && (phase_reg == PHASE_BITS'(DECIMATION - 1));
    assign emit     = tick && (state_reg == RUN);
    assign transfer = sample_valid && sample_ready;

    // Integrator inputs come from the previous stage's old value (pipelined chain).
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_chain
            if (gi == 0) begin : g_first
                assign integ_in[gi] = {{(OUT_BITS - MOD_BITS){1'b0}}, dsm_bit};
                assign comb_in[gi]  = integ_reg[STAGES-1];
            end else begin : g_rest
                assign integ_in[gi] = integ_reg[gi-1];
                assign comb_in[gi]  = comb_out[gi-1];
            end
            assign comb_out[gi] = comb_in[gi] - comb_dly_reg[gi];
        end
    endgenerate

    always_ff @(posedge internal_clk or posedge internal_rst) begin
        if (internal_rst) begin
            state_reg    <= IDLE;
            phase_reg    <= '0;
            discard_reg  <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            sample_count <= '0;
            for (int i = 0; i < STAGES; i++) begin
                integ_reg[i]    <= '0;
                comb_dly_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE:    if (enable) state_reg <= SETTLE;
                SETTLE:  if (!enable) state_reg <= IDLE;
                         else if (tick && discard_reg == 2'd2) state_reg <= RUN;
                RUN:     if (!enable) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            if (go_idle) begin
                phase_reg   <= '0;
                discard_reg <= '0;
                for (int i = 0; i < STAGES; i++) begin
                    integ_reg[i]    <= '0;
                    comb_dly_reg[i] <= '0;
                end
            end else if (accept) begin
                phase_reg <= phase_reg + 1'b1;
                for (int i = 0; i < STAGES; i++)
                    integ_reg[i] <= integ_reg[i] + integ_in[i];
                if (tick) begin
                    for (int i = 0; i < STAGES; i++)
                        comb_dly_reg[i] <= comb_in[i];
                    if (state_reg == SETTLE)
                        discard_reg <= discard_reg + 2'd1;
                end
            end

            // A new sample may replace the pending one only if that one leaves this cycle.
            if (emit && (!sample_valid || sample_ready)) begin
                sample_data  <= comb_out[STAGES-1];
                sample_valid <= 1'b1;
            end else if (transfer) begin
                sample_valid <= 1'b0;
            end

            if (emit && sample_valid && !sample_ready)
                overrun <= 1'b1;
            else if (clear_overrun)
                overrun <= 1'b0;

            if (transfer)
                sample_count <= sample_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_dsm_decimator.sv
// Bench for dsm_decimator: a direct sinc3 convolution model predicts each emitted
// sample into a queue; a monitor pops and compares on every handshake transfer.
module tb_dsm_decimator;
    localparam int MB = 4;
    localparam int R  = 64;
    localparam int OB = 22;
    localparam int HL = 3 * R - 2;

    logic          internal_clk = 1'b0;
    logic          internal_rst;
    logic          enable;
    logic [MB-1:0] dsm_bit;
    logic          dsm_valid;
    logic [OB-1:0] sample_data;
    logic          sample_valid;
    logic          sample_ready;
    logic          overrun;
    logic          clear_overrun;
    logic [15:0]   sample_count;

    always #5 internal_clk = ~internal_clk;

    dsm_decimator #(.MOD_BITS(MB), .DECIMATION(R)) dut (
        .internal_clk (internal_clk),
        .internal_rst (internal_rst),
        .enable       (enable),
        .dsm_bit      (dsm_bit),
        .dsm_valid    (dsm_valid),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .clear_overrun(clear_overrun),
        .sample_count (sample_count)
    );

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [OB-1:0] exp_q[$];
    longint        h [HL];
    int            hist [2048];
    int            n_acc;
    bit            m_active, m_valid, m_overrun;
    int            m_count;

    // sinc3 impulse response = three length-R boxes convolved.
    task automatic build_h();
        longint b2 [2*R-1];
        for (int i = 0; i < 2*R-1; i++) b2[i] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++) b2[a+b] += 1;
        for (int i = 0; i < HL; i++) h[i] = 0;
        for (int a = 0; a < 2*R-1; a++)
            for (int c = 0; c < R; c++) h[a+c] += b2[a];
    endtask

    // Output at decimation tick k covers accepted inputs up to index k*R-4.
    function automatic logic [OB-1:0] model_y(input int k);
        longint acc;
        int     base, idx;
        acc  = 0;
        base = k * R - 4;
        for (int j = 0; j < HL; j++) begin
            idx = base - j;
            if (idx >= 0) acc += h[j] * hist[idx];
        end
        return acc[OB-1:0];
    endfunction

    task automatic model_clear();
        exp_q.delete();
        n_acc = 0; m_active = 0; m_valid = 0; m_overrun = 0; m_count = 0;
    endtask

    // Drive one cycle of input and advance the reference model across the same edge.
    task automatic cyc(input bit v, input int code);
        bit acc, tick_run, transfer, drop;
        dsm_valid = v;
        dsm_bit   = code[MB-1:0];
        acc       = m_active && enable && v;
        tick_run  = 0;
        drop      = 0;
        transfer  = m_valid && sample_ready;
        if (m_active && !enable) begin
            n_acc = 0;
        end else if (acc) begin
            if (n_acc < 2048) hist[n_acc] = code;
            n_acc++;
            if ((n_acc % R) == 0 && (n_acc / R) >= 4) tick_run = 1;
        end
        if (tick_run && m_valid && !sample_ready) begin
            drop = 1;
            m_overrun = 1;
        end else if (tick_run) begin
            exp_q.push_back(model_y(n_acc / R));
            m_valid = 1;
        end else if (transfer) begin
            m_valid = 0;
        end
        if (clear_overrun && !drop) m_overrun = 0;
        if (transfer) m_count++;
        m_active = enable;
        @(posedge internal_clk);
        #1;
    endtask

    task automatic restart();
        enable = 1'b0;
        cyc(0, 0);
        cyc(0, 0);
        enable = 1'b1;
        cyc(0, 0);
    endtask

    task automatic drain();
        sample_ready = 1'b1;
        repeat (3) cyc(0, 0);
    endtask

    always @(negedge internal_clk) begin
        logic [OB-1:0] e;
        if (!internal_rst && sample_valid === 1'b1 && sample_ready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_unexpected: got sample %h, expected no sample", sample_data);
            end else begin
                e = exp_q.pop_front();
                if (sample_data !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard_data: got %h, expected %h", sample_data, e);
                end else
                    $display("transfer: sample %h ok", sample_data);
            end
        end
    end

    task automatic test_reset();
        internal_rst = 1'b1; enable = 1'b0; dsm_valid = 1'b0; dsm_bit = '0;
        sample_ready = 1'b0; clear_overrun = 1'b0;
        model_clear();
        #12;
        n_cmp++;
        if ({sample_valid, overrun, sample_data, sample_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b ovr=%b data=%h cnt=%0d, expected all 0",
                     sample_valid, overrun, sample_data, sample_count);
        end
        @(posedge internal_clk); #1;
        internal_rst = 1'b0;
        sample_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            cyc(1, 15);
            n_cmp++;
            if ({sample_valid, overrun, sample_data, sample_count} !== '0) begin
                n_fail++;
                $display("FAIL idle_outputs: cycle %0d got valid=%b data=%h cnt=%0d, expected 0",
                         i, sample_valid, sample_data, sample_count);
            end
        end
    endtask

    task automatic test_constant();
        sample_ready = 1'b1;
        restart();
        repeat (255) cyc(1, 15);
        n_cmp++;
        if (sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL const_early_valid: got %b after 255 inputs, expected 0", sample_valid);
        end
        cyc(1, 15);
        n_cmp++;
        if (sample_valid !== 1'b1 || sample_data !== 22'h3C0000) begin
            n_fail++;
            $display("FAIL const_first_sample: got valid=%b data=%h, expected 1 / 3c0000",
                     sample_valid, sample_data);
        end
        repeat (3 * R) cyc(1, 15);
        n_cmp++;
        if (sample_count !== 16'(m_count) || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL const_count: got cnt=%0d ovr=%b, expected %0d / 0", sample_count, overrun, m_count);
        end
        drain();
    endtask

    task automatic test_step();
        sample_ready = 1'b1;
        restart();
        repeat (5 * R) cyc(1, 0);
        n_cmp++;
        if (sample_data !== '0) begin
            n_fail++;
            $display("FAIL step_before: got %h, expected 0", sample_data);
        end
        repeat (6 * R) cyc(1, 8);
        n_cmp++;
        if (sample_data !== 22'h200000) begin
            n_fail++;
            $display("FAIL step_steady: got %h, expected 200000", sample_data);
        end
        drain();
    endtask

    task automatic test_backpressure();
        sample_ready = 1'b0;
        restart();
        repeat (256) cyc(1, 5);
        n_cmp++;
        if (sample_valid !== 1'b1 || sample_data !== 22'h140000) begin
            n_fail++;
            $display("FAIL bp_first: got valid=%b data=%h, expected 1 / 140000", sample_valid, sample_data);
        end
        for (int i = 0; i < 130; i++) begin
            cyc(1, 5);
            n_cmp++;
            if (sample_valid !== 1'b1 || sample_data !== 22'h140000) begin
                n_fail++;
                $display("FAIL bp_hold: input %0d got valid=%b data=%h, expected 1 / 140000",
                         i, sample_valid, sample_data);
            end
        end
        n_cmp++;
        if (overrun !== 1'b1 || sample_count !== 16'(m_count)) begin
            n_fail++;
            $display("FAIL bp_overrun: got ovr=%b cnt=%0d, expected 1 / %0d", overrun, sample_count, m_count);
        end
        clear_overrun = 1'b1;
        cyc(0, 0);
        clear_overrun = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_clear: got ovr=%b, expected 0", overrun);
        end
        drain();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_queue: %0d samples left, expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int cnt_before;
        sample_ready = 1'b0;
        restart();
        repeat (256) cyc(1, 3);
        repeat (R - 1) cyc(1, 9);
        cnt_before   = m_count;
        sample_ready = 1'b1;
        cyc(1, 9);
        sample_ready = 1'b0;
        n_cmp++;
        if (sample_valid !== 1'b1 || overrun !== 1'b0 || sample_count !== 16'(cnt_before + 1)) begin
            n_fail++;
            $display("FAIL b2b_flags: got valid=%b ovr=%b cnt=%0d, expected 1 / 0 / %0d",
                     sample_valid, overrun, sample_count, cnt_before + 1);
        end
        n_cmp++;
        if (exp_q.size() != 1 || sample_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL b2b_new_data: got %h (queue %0d), expected newly loaded sample", sample_data, exp_q.size());
        end
        drain();
    endtask

    task automatic test_enable_drop();
        sample_ready = 1'b1;
        restart();
        repeat (300) cyc(1, 7);
        enable = 1'b0;
        repeat (3) cyc(1, 7);
        enable = 1'b1;
        cyc(1, 7);
        repeat (255) cyc(1, 7);
        n_cmp++;
        if (sample_valid !== 1'b0 || sample_count !== 16'(m_count)) begin
            n_fail++;
            $display("FAIL reenable_settle: got valid=%b cnt=%0d, expected 0 / %0d", sample_valid, sample_count, m_count);
        end
        cyc(1, 7);
        n_cmp++;
        if (sample_valid !== 1'b1 || sample_data !== 22'h1C0000) begin
            n_fail++;
            $display("FAIL reenable_first: got valid=%b data=%h, expected 1 / 1c0000", sample_valid, sample_data);
        end
        drain();
    endtask

    task automatic test_async_reset();
        sample_ready = 1'b0;
        restart();
        repeat (266) cyc(1, 15);
        n_cmp++;
        if (sample_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pending: got valid=%b, expected 1", sample_valid);
        end
        #2;
        internal_rst = 1'b1;
        #1;
        n_cmp++;
        if ({sample_valid, overrun, sample_data, sample_count} !== '0) begin
            n_fail++;
            $display("FAIL arst_outputs: got valid=%b ovr=%b data=%h cnt=%0d, expected all 0",
                     sample_valid, overrun, sample_data, sample_count);
        end
        model_clear();
        enable = 1'b0;
        @(posedge internal_clk); #1;
        internal_rst = 1'b0;
        cyc(0, 0);
    endtask

    initial begin
        build_h();
        test_reset();
        test_constant();
        test_step();
        test_backpressure();
        test_back_to_back();
        test_enable_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
